nibbler_ctrl: RTL and testbench
===============================

Name: nibbler_ctrl

Overview:
Fetch/execute sequencer for the 4-bit Nibbler datapath. Drives the program-ROM address and latches each instruction byte. Decodes it into ALU select, immediate operand and the one-cycle load enable for the downstream accumulator register. Holds the carry/zero flags and resolves two-byte jumps.

Parameters:
PC_W, 12, program counter / ROM address width
RESET_PC, 12'h000, PC value loaded on reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET_N  input  1  asynchronous, active-low reset
rom_data  input  8  instruction byte at address pc, valid combinationally in the same cycle
alu_carry  input  1  carry-out of ALU for current alu_op/operand
alu_zero  input  1  ALU result == 4'h0
pc  output  PC_W  ROM address (registered)
operand  output  4  immediate nibble to ALU B input (IR[3:0])
alu_op  output  2  00 PASS_B, 01 ADD, 10 NAND, 11 reserved (never driven)
acc_enable  output  1  accumulator load enable, one cycle per ALU instruction
carry_flag  output  1  registered C flag
zero_flag  output  1  registered Z flag
halted  output  1  high while in HALT state (0 when CTRL_HALT_EN undefined)

Behaviour:
- Reset is asynchronous on RESET_N low, including mid-instruction. While low: state=FETCH, pc=RESET_PC, IR=8'h00, carry_flag=0, zero_flag=0, acc_enable=0, alu_op=00, operand=0, halted=0.
- Instruction byte = {opcode[7:4], imm[3:0]}. Jumps are two bytes: byte0={op, addr[11:8]}, byte1=addr[7:0].
- States: FETCH, EXEC, JUMP, HALT (optional).
- FETCH: at the edge, IR<=rom_data and pc<=pc+1. Next state is EXEC. acc_enable=0.
- EXEC, by opcode:
  - 0x0 NOP: no effect.
  - 0x1 LDI: alu_op=00, acc_enable=1, Z<=alu_zero, C unchanged.
  - 0x2 ADDI: alu_op=01, acc_enable=1, C<=alu_carry, Z<=alu_zero.
  - 0x3 NANDI: alu_op=10, acc_enable=1, Z<=alu_zero, C unchanged.
  - 0x8 JMP, 0x9 JC, 0xA JZ, 0xB JNZ: next state JUMP, no flag change.
  - All other opcodes: NOP (0xF see Optional Feature).
  - Non-jump next state is FETCH.
- acc_enable and alu_op are combinational from state+IR. acc_enable is high exactly one cycle (EXEC), and the accumulator captures on the same rising edge that updates the flags.
- JUMP: rom_data is byte1 at current pc. Taken condition: JMP always; JC if carry_flag; JZ if zero_flag; JNZ if !zero_flag. Flags are sampled as held during JUMP.
  - Taken: pc<={IR[3:0], rom_data}.
  - Not taken: pc<=pc+1.
  - Next state is FETCH.
- Latency: ALU instruction = 2 cycles; jump = 3 cycles, taken or not.
- pc wraps 12'hFFF+1 -> 12'h000, including when byte1 of a jump lies at 12'h000 after wrap.
- operand=IR[3:0] in all states. alu_op=00 outside EXEC ALU ops.

Optional Feature:
Macro CTRL_HALT_EN.
- Defined: opcode 0xF in EXEC enters HALT. In HALT: pc frozen, acc_enable=0, flags held, halted=1. Only RESET_N exits HALT.
- Undefined: 0xF decodes as NOP, HALT state is not built, halted tied 0.

Test Plan:
- Reset: RESET_N low mid-EXEC of ADDI -> immediately pc=0, acc_enable=0, flags 0. First edge after release latches IR from ROM[0].
- ROM {0x15, 0x2C} -> LDI: acc_enable high with alu_op=00, operand=5. ADDI: alu_op=01, operand=C. With alu_carry=1, alu_zero=1 -> C=1, Z=1 one edge later. pc=2 after 4 cycles.
- ROM {0x3F} with alu_zero=0 -> NANDI: Z=0, C unchanged from previous value.
- Taken jump: C=1, ROM[4..5]={0x9A, 0x3C} -> pc=0xA3C exactly 3 cycles after FETCH of addr 4. Untaken with C=0 -> pc=6.
- Wrap: JMP byte0 at 0xFFF, byte1 at 0x000 = 0x10, byte0 low nibble 2 -> pc=0x210. NOP at 0xFFF -> pc=0x000.
- CTRL_HALT_EN defined: 0xF0 -> halted=1, pc stable for 10 cycles, acc_enable 0. Undefined: pc advances as NOP.

Source files
------------

// File: rtl/nibbler_ctrl.sv
// nibbler_ctrl -- fetch/execute sequencer for the 4-bit Nibbler datapath.
//
// Walks the program ROM one byte per fetch. It latches each instruction
// into IR and decodes it into an ALU select, an immediate operand and a
// one-cycle accumulator load strobe. It also holds the C/Z flags and
// resolves two-byte jumps (byte0 = {op, addr[11:8]}, byte1 = addr[7:0]).
//
// Optional feature: define CTRL_HALT_EN to build the HALT state (opcode 0xF).
// Without it, 0xF is a NOP and halted is tied low.
//
// Ports:
//   CLK         system clock, rising edge
//   RESET_N     asynchronous active-low reset
//   rom_data    instruction byte at address pc (combinational ROM read)
//   alu_carry   ALU carry-out for the current alu_op/operand
//   alu_zero    ALU result == 0
//   pc          registered ROM address
//   operand     IR[3:0], immediate for the ALU B input
//   alu_op      00 PASS_B, 01 ADD, 10 NAND (11 never driven)
//   acc_enable  accumulator load strobe, high for the single EXEC cycle of
//               an ALU instruction; the accumulator and the flags both
//               capture on the rising edge that ends that cycle
//   carry_flag  registered C flag
//   zero_flag   registered Z flag
//   halted      high while in HALT
//   state_dbg   FSM state: 0 FETCH, 1 EXEC, 2 JUMP, 3 HALT
//
// Handshake: there is no valid/ready pairing here. rom_data is assumed valid
// in the same cycle as pc. acc_enable is a qualifier with no back-pressure:
// the accumulator must take the ALU result on every edge where it is high.

module nibbler_ctrl #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [7:0]      rom_data,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      operand,
  output logic [1:0]      alu_op,
  output logic            acc_enable,
  output logic            carry_flag,
  output logic            zero_flag,
  output logic            halted,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_JUMP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            c_q, c_d;
  logic            z_q, z_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;
  logic            jump_taken;
  logic            acc_en_c;
  logic [1:0]      alu_op_c;

  // The natural overflow of the adder gives the required wrap from the top
  // of the ROM back to address 0.
  assign pc_inc      = pc_q + PC_W'(1);
  assign jump_target = PC_W'({ir_q[3:0], rom_data});

  // Opcodes 0x8..0xB differ only in IR[5:4], so those two bits select the
  // condition. The flags are the values already held, so an ALU result
  // that is still in flight cannot affect the jump.
  always_comb begin
    jump_taken = 1'b0;
    case (ir_q[5:4])
      2'b00:   jump_taken = 1'b1;
      2'b01:   jump_taken = c_q;
      2'b10:   jump_taken = z_q;
      default: jump_taken = ~z_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    c_d      = c_q;
    z_d      = z_q;
    acc_en_c = 1'b0;
    alu_op_c = OP_PASS;
    case (state_q)
      S_FETCH: begin
        ir_d    = rom_data;
        pc_d    = pc_inc;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[7:4])
          4'h1: begin
            alu_op_c = OP_PASS;
            acc_en_c = 1'b1;
            z_d      = alu_zero;
          end
          4'h2: begin
            alu_op_c = OP_ADD;
            acc_en_c = 1'b1;
            c_d      = alu_carry;
            z_d      = alu_zero;
          end
          4'h3: begin
            alu_op_c = OP_NAND;
            acc_en_c = 1'b1;
            z_d      = alu_zero;
          end
          4'h8, 4'h9, 4'hA, 4'hB: state_d = S_JUMP;
`ifdef CTRL_HALT_EN
          4'hF: state_d = S_HALT;
`endif
          default: ;
        endcase
      end
      S_JUMP: begin
        // rom_data is byte1 of the jump, read at the current pc.
        pc_d    = jump_taken ? jump_target : pc_inc;
        state_d = S_FETCH;
      end
`ifdef CTRL_HALT_EN
      S_HALT: begin
        // Everything is held. Only RESET_N leaves this state.
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  assign pc         = pc_q;
  assign operand    = ir_q[3:0];
  assign alu_op     = alu_op_c;
  assign acc_enable = acc_en_c;
  assign carry_flag = c_q;
  assign zero_flag  = z_q;
  assign state_dbg  = state_q;

`ifdef CTRL_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_nibbler_ctrl.sv
// tb_nibbler_ctrl -- bench for nibbler_ctrl.
//
// The bench supplies a program ROM and a small accumulator/ALU environment
// around the controller. An instruction-level model runs each program ahead
// of time. For every instruction it predicts the retire record
// {pc, C, Z, cycles} and each accumulator strobe {alu_op, operand}.
// A monitor compares these against the DUT as the outputs appear.

module tb_nibbler_ctrl;

  localparam logic [1:0] FETCH_DBG = 2'd0;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  rom_data;
  logic        alu_carry, alu_zero;
  logic [11:0] pc;
  logic [3:0]  operand;
  logic [1:0]  alu_op;
  logic        acc_enable, carry_flag, zero_flag, halted;
  logic [1:0]  state_dbg;

  logic [7:0]  rom [4096];

  nibbler_ctrl #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .rom_data(rom_data),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .pc(pc),
    .operand(operand), .alu_op(alu_op), .acc_enable(acc_enable),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .halted(halted),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- environment: ROM + accumulator/ALU ----------------
  assign rom_data = rom[pc];

  logic [3:0] env_acc, alu_res;
  logic       alu_cout;

  always_comb begin
    alu_res  = 4'h0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00:   alu_res = operand;
      2'b01:   {alu_cout, alu_res} = {1'b0, env_acc} + {1'b0, operand};
      2'b10:   alu_res = ~(env_acc & operand);
      default: alu_res = 4'h0;
    endcase
  end
  assign alu_carry = alu_cout;
  assign alu_zero  = (alu_res == 4'h0);

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        env_acc <= 4'h0;
    else if (acc_enable) env_acc <= alu_res;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];   // {pc[11:0], c, z, cycles[1:0]}
  logic [5:0]  alu_q[$];   // {alu_op, operand}
  bit          mon_en = 1'b0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET_N || !mon_en) begin
      cyc = 0;
    end else begin
      logic [15:0] e;
      logic [5:0]  a;
      cyc++;
      if (acc_enable) begin
        if (alu_q.size() == 0) begin
          check("alu_unexpected_strobe", {alu_op, operand}, 6'h3f);
        end else begin
          a = alu_q.pop_front();
          check("alu_op", alu_op, a[5:4]);
          check("alu_operand", operand, a[3:0]);
        end
      end else begin
        check("alu_op_idle", alu_op, 2'b00);
      end
      if (state_dbg == FETCH_DBG) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch_pc", pc, 12'hfff + 32'h1000);
        end else begin
          e = exp_q.pop_front();
          check("retire_pc", pc, e[15:4]);
          check("retire_carry", carry_flag, e[3]);
          check("retire_zero", zero_flag, e[2]);
          check("retire_latency", cyc, e[1:0]);
        end
        cyc = 0;
      end
    end
  end

  // ---------------- reference model (instruction level) ----------------
  logic [11:0] m_pc;
  logic        m_c, m_z, m_halt;
  logic [3:0]  m_acc;

  task automatic model_step();
    logic [7:0] b0, b1;
    logic [4:0] sum;
    int         lat;
    bit         take;
    if (m_halt) return;
    b0   = rom[m_pc];
    m_pc = m_pc + 12'd1;
    lat  = 2;
    case (b0[7:4])
      4'h1: begin
        m_acc = b0[3:0];
        m_z   = (m_acc == 4'h0);
        alu_q.push_back({2'b00, b0[3:0]});
      end
      4'h2: begin
        sum   = {1'b0, m_acc} + {1'b0, b0[3:0]};
        m_c   = sum[4];
        m_acc = sum[3:0];
        m_z   = (m_acc == 4'h0);
        alu_q.push_back({2'b01, b0[3:0]});
      end
      4'h3: begin
        m_acc = ~(m_acc & b0[3:0]);
        m_z   = (m_acc == 4'h0);
        alu_q.push_back({2'b10, b0[3:0]});
      end
      4'h8, 4'h9, 4'hA, 4'hB: begin
        b1  = rom[m_pc];
        lat = 3;
        case (b0[7:4])
          4'h8:    take = 1'b1;
          4'h9:    take = m_c;
          4'hA:    take = m_z;
          default: take = !m_z;
        endcase
        m_pc = take ? {b0[3:0], b1} : m_pc + 12'd1;
      end
`ifdef CTRL_HALT_EN
      4'hF: begin
        m_halt = 1'b1;
        return;
      end
`endif
      default: ;
    endcase
    exp_q.push_back({m_pc, m_c, m_z, 2'(lat)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic random_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_program(input int n_instr);
    int budget;
    RESET_N = 1'b0;
    exp_q.delete();
    alu_q.delete();
    m_pc = 12'h000; m_c = 1'b0; m_z = 1'b0; m_acc = 4'h0; m_halt = 1'b0;
    exp_q.push_back({12'h000, 1'b0, 1'b0, 2'd1});
    repeat (n_instr) model_step();
    mon_en = 1'b1;
    @(posedge CLK); #2 RESET_N = 1'b1;
    budget = n_instr * 3 + 20;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (exp_q.size() == 0 && alu_q.size() == 0) break;
    end
    check("drain_outstanding", exp_q.size() + alu_q.size(), 0);
    mon_en = 1'b0;
    if (m_halt) begin
      @(posedge CLK);
      repeat (10) begin
        @(negedge CLK);
        check("halt_pc_frozen", pc, m_pc);
        check("halt_flag", halted, 1'b1);
        check("halt_acc_enable", acc_enable, 1'b0);
      end
    end else begin
      @(negedge CLK);
      check("halted_low", halted, 1'b0);
    end
    RESET_N = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    RESET_N = 1'b0;
    clear_rom();
    repeat (2) @(posedge CLK);

    // Reset asserted in the middle of an ADDI's EXEC cycle.
    rom[0] = 8'h15; rom[1] = 8'h2C;
    @(posedge CLK); #2 RESET_N = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (acc_enable && alu_op == 2'b01) begin found = 1'b1; break; end
    end
    check("reset_reach_addi", found, 1'b1);
    RESET_N = 1'b0;
    #1;
    check("rst_pc", pc, 12'h000);
    check("rst_acc_enable", acc_enable, 1'b0);
    check("rst_carry", carry_flag, 1'b0);
    check("rst_zero", zero_flag, 1'b0);
    check("rst_alu_op", alu_op, 2'b00);
    check("rst_operand", operand, 4'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_state", state_dbg, FETCH_DBG);
    @(posedge CLK); #2 RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("first_fetch_operand", operand, 4'h5);
    check("first_fetch_pc", pc, 12'h001);
    RESET_N = 1'b0;

    // LDI 5, ADDI C, NANDI F
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h2C; rom[2] = 8'h3F;
    run_program(3);

    // JC taken: LDI F, ADDI 1 sets C, NOP, NOP, JC 0xA3C
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[4] = 8'h9A; rom[5] = 8'h3C;
    run_program(6);

    // JC not taken with C = 0
    clear_rom();
    rom[0] = 8'h10; rom[4] = 8'h9A; rom[5] = 8'h3C;
    run_program(6);

    // JMP whose byte0 is at 0xFFF and byte1 wraps to 0x000
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h8F; rom[2] = 8'hFF; rom[12'hFFF] = 8'h82;
    run_program(4);

    // NOP at 0xFFF wraps pc to 0x000
    clear_rom();
    rom[0] = 8'h8F; rom[1] = 8'hFF;
    run_program(4);

    // Opcode 0xF: HALT when built in, NOP otherwise
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'hF0; rom[2] = 8'h2E;
    run_program(4);

    // Random programs
    for (int p = 0; p < 8; p++) begin
      random_rom();
      run_program(150);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
